// File: rtl/wu_fetch_pkg.sv
// wu_fetch_pkg: shared state encoding and default widths for the
// work-unit fetch stage (wu_fetch) and its program counter (wu_fetch_pc).
package wu_fetch_pkg;

    // Instruction address width of the manager WU memory.
    localparam int WU_FETCH_ADDR_WIDTH     = 10;
    // Remaining-passes counter width (WU_FETCH_LOOP_EN builds only).
    localparam int WU_FETCH_LOOP_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        WUF_IDLE  = 2'd0,
        WUF_FETCH = 2'd1,
        WUF_DONE  = 2'd2
    } wuf_state_e;

endpackage

// File: rtl/wu_fetch_pc.sv
// wu_fetch_pc: program counter for the WU fetch stage.
// Ports: load (latch start/end), step (advance after an unstalled read),
//   pc (current address), last (pc is the final address of the program).
// With WU_FETCH_LOOP_EN defined: clear, loop_count, and a reload of the
//   start address for each extra pass.
module wu_fetch_pc
    import wu_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH     = WU_FETCH_ADDR_WIDTH
`ifdef WU_FETCH_LOOP_EN
    ,
    parameter int LOOP_CNT_WIDTH = WU_FETCH_LOOP_CNT_WIDTH
`endif
) (
    input  logic                      clk,
    input  logic                      reset_poweron,
    input  logic                      load,
    input  logic                      step,
`ifdef WU_FETCH_LOOP_EN
    input  logic                      clear,
    input  logic [LOOP_CNT_WIDTH-1:0] loop_count,
`endif
    input  logic [ADDR_WIDTH-1:0]     start_addr,
    input  logic [ADDR_WIDTH-1:0]     end_addr,
    output logic [ADDR_WIDTH-1:0]     pc,
    output logic                      last
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] end_q, end_d;
    logic                  at_end;

    assign at_end = (pc_q == end_q);
    assign pc     = pc_q;

`ifdef WU_FETCH_LOOP_EN
    logic [ADDR_WIDTH-1:0]     base_q, base_d;
    logic [LOOP_CNT_WIDTH-1:0] rem_q, rem_d;

    assign last = at_end && (rem_q == '0);
`else
    assign last = at_end;
`endif

    always_comb begin
        pc_d  = pc_q;
        end_d = end_q;
`ifdef WU_FETCH_LOOP_EN
        base_d = base_q;
        rem_d  = rem_q;
`endif
        if (load) begin
            pc_d  = start_addr;
            end_d = end_addr;
`ifdef WU_FETCH_LOOP_EN
            base_d = start_addr;
            rem_d  = loop_count;
`endif
        end else if (step && !at_end) begin
            pc_d = pc_q + 1'b1;
        end
`ifdef WU_FETCH_LOOP_EN
        else if (step && !last) begin
            // Wrap back for another pass with no bubble.
            pc_d  = base_q;
            rem_d = rem_q - 1'b1;
        end
        if (clear) begin
            rem_d = '0;
        end
`endif
        // On the final address pc holds, so it never wraps past the top.
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            pc_q  <= '0;
            end_q <= '0;
`ifdef WU_FETCH_LOOP_EN
            base_q <= '0;
            rem_q  <= '0;
`endif
        end else begin
            pc_q  <= pc_d;
            end_q <= end_d;
`ifdef WU_FETCH_LOOP_EN
            base_q <= base_d;
            rem_q  <= rem_d;
`endif
        end
    end

endmodule

// File: rtl/wu_fetch.sv
// wu_fetch: work-unit instruction fetch stage; walks start..end (inclusive),
// one read per unstalled cycle, reports busy and a one-cycle done pulse.
// Inputs: start/start_addr/end_addr/abort from the controller, stall from
//   the memory stage. Outputs (all registered): addr, read, busy, done.
// Optional WU_FETCH_LOOP_EN adds mcntl__wuf__loop_count (extra passes).
module wu_fetch
    import wu_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH     = WU_FETCH_ADDR_WIDTH
`ifdef WU_FETCH_LOOP_EN
    ,
    parameter int LOOP_CNT_WIDTH = WU_FETCH_LOOP_CNT_WIDTH
`endif
) (
    input  logic                      clk,
    input  logic                      reset_poweron,
    input  logic                      mcntl__wuf__start,
    input  logic [ADDR_WIDTH-1:0]     mcntl__wuf__start_addr,
    input  logic [ADDR_WIDTH-1:0]     mcntl__wuf__end_addr,
    input  logic                      mcntl__wuf__abort,
`ifdef WU_FETCH_LOOP_EN
    input  logic [LOOP_CNT_WIDTH-1:0] mcntl__wuf__loop_count,
`endif
    input  logic                      wum__wuf__stall,
    output logic [ADDR_WIDTH-1:0]     wuf__wum__addr,
    output logic                      wuf__wum__read,
    output logic                      wuf__mcntl__busy,
    output logic                      wuf__mcntl__done
);

    wuf_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  read_q, read_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pc_load, pc_step, pc_last;
    logic [ADDR_WIDTH-1:0] pc;

    wu_fetch_pc #(
        .ADDR_WIDTH     (ADDR_WIDTH)
`ifdef WU_FETCH_LOOP_EN
        ,
        .LOOP_CNT_WIDTH (LOOP_CNT_WIDTH)
`endif
    ) u_pc (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .load          (pc_load),
        .step          (pc_step),
`ifdef WU_FETCH_LOOP_EN
        .clear         (mcntl__wuf__abort),
        .loop_count    (mcntl__wuf__loop_count),
`endif
        .start_addr    (mcntl__wuf__start_addr),
        .end_addr      (mcntl__wuf__end_addr),
        .pc            (pc),
        .last          (pc_last)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        read_d  = 1'b0;
        pc_load = 1'b0;
        pc_step = 1'b0;
        if (mcntl__wuf__abort) begin
            state_d = WUF_IDLE;
        end else begin
            unique case (state_q)
                WUF_IDLE: begin
                    if (mcntl__wuf__start) begin
                        pc_load = 1'b1;
                        if (mcntl__wuf__start_addr <= mcntl__wuf__end_addr)
                            state_d = WUF_FETCH;
                        else
                            state_d = WUF_DONE;
                    end
                end
                WUF_FETCH: begin
                    if (!wum__wuf__stall) begin
                        read_d  = 1'b1;
                        addr_d  = pc;
                        pc_step = 1'b1;
                        if (pc_last)
                            state_d = WUF_DONE;
                    end
                end
                WUF_DONE: state_d = WUF_IDLE;
                default:  state_d = WUF_IDLE;
            endcase
        end
        // Busy covers the final read cycle; done lags DONE entry by one
        // edge so it lands the cycle after the last read.
        busy_d = (state_d == WUF_FETCH) ||
                 ((state_q == WUF_FETCH) && (state_d == WUF_DONE));
        done_d = (state_q == WUF_DONE);
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q <= WUF_IDLE;
            addr_q  <= '0;
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign wuf__wum__addr   = addr_q;
    assign wuf__wum__read   = read_q;
    assign wuf__mcntl__busy = busy_q;
    assign wuf__mcntl__done = done_q;

endmodule
